ccff_loader: RTL and testbench
==============================

Name: ccff_loader

Overview:
- Bitstream writer for the configuration chain: drives the serial ccff_head input of a daisy-chained tile row and reads its ccff_tail output.
- Accepts configuration words from the host over a valid/ready stream and shifts them LSB-first into CHAIN_LEN configuration flops.
- Optionally runs a second pass that verifies the chain contents against a re-sent copy of the bitstream.
- Sits between the configuration DMA/host port and the first tile of the fabric, in the prog_clk domain.

Parameters:
- CHAIN_LEN, 1024: number of configuration flops in the chain (≥2).
- WORD_W, 32: host word width in bits (≥2).
- CNT_W, 16: width of the saturating mismatch counter.

Ports:
- prog_clk  input  1  configuration clock; all state on the rising edge.
- pReset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; ignored unless the state is IDLE.
- verify_en  input  1  sampled with start; when 1, a VERIFY pass follows LOAD.
- abort  input  1  synchronous; returns the block to IDLE from any state.
- s_data  input  WORD_W  bitstream word; bit 0 is shifted first.
- s_valid  input  1  s_data valid.
- s_ready  output  1  word accepted when s_valid and s_ready are both high.
- ccff_head  output  1  serial bit to the chain.
- ccff_en  output  1  chain shift enable (gates prog_clk to the chain externally).
- ccff_tail  input  1  serial output of the last flop in the chain.
- busy  output  1  high in LOAD or VERIFY.
- done  output  1  one-cycle pulse on completion.
- mismatch_cnt  output  CNT_W  verify mismatches, saturating.
- err  output  1  mismatch_cnt != 0.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, word buffer empty.
- States and transitions:
  - IDLE → LOAD on start. verify_en is latched and mismatch_cnt is cleared in the same cycle.
  - LOAD → VERIFY when the last bit of the pass is shifted and verify_en was latched high; otherwise LOAD → DONE.
  - VERIFY → DONE when the last bit of the pass is shifted.
  - DONE → IDLE after one cycle; done = 1 only in DONE.
- Shift datapath:
  - WORD_W-bit buffer word_q, valid flag vld_q, bit index bidx.
  - ccff_head = word_q[0] and ccff_en = vld_q & busy. Both come straight from flops, with no combinational path from any input.
  - Each cycle with ccff_en high is one shift: word_q shifts right, bidx increments, and bit_cnt increments.
- Pass length: a pass is exactly CHAIN_LEN shifts and NW = ceil(CHAIN_LEN/WORD_W) words.
  - Bits of the last word beyond CHAIN_LEN are discarded (vld_q cleared, never shifted).
  - word_cnt counts words accepted per pass; s_ready is 0 once NW words are accepted in the pass.
- s_ready = busy & (word_cnt < NW) & (!vld_q | (ccff_en & bidx == WORD_W-1)).
  - This gives back-to-back words with no bubble: sustained rate is 1 bit/cycle when s_valid is held high.
  - An s_valid gap leaves ccff_en low; the chain holds its state and no bit is lost or duplicated.
- VERIFY pass: the host re-sends the identical bitstream, so the chain contents are unchanged afterwards.
  - On every shift, ccff_tail is compared with ccff_head.
  - The flop at the tail holds pass-1 bit i when pass-2 bit i is being shifted.
  - Each inequality increments mismatch_cnt, saturating at 2^CNT_W-1.
- Counters:
  - bit_cnt is $clog2(CHAIN_LEN+1) bits wide and resets to 0 at each pass boundary.
  - word_cnt and bidx also clear at each pass boundary.
- abort: takes priority over all other events.
  - Next cycle: state IDLE, ccff_en = 0, vld_q = 0, s_ready = 0, no done pulse.
  - mismatch_cnt holds its value.
- start while busy is ignored. start and abort in the same IDLE cycle: abort wins and the state stays IDLE.
- pReset deassertion mid-load leaves the chain partially written. The loader restarts from IDLE; the chain itself is not reset by this block.
- mismatch_cnt and err hold after DONE until the next accepted start.

Decomposition:
- Package ccff_pkg:
  - state enum {IDLE, LOAD, VERIFY, DONE}.
  - NW and counter-width localparam functions (ceil division, $clog2 wrappers).
- One natural sub-module, ccff_word_serializer. It contains word_q, vld_q, bidx, the s_ready logic and the last-word truncation, and is parameterised by WORD_W.
- The FSM, pass counters and verify comparator stay in ccff_loader.

Test Plan (CHAIN_LEN=10, WORD_W=4, NW=3; chain modelled as a 10-flop shift register enabled by ccff_en):
- Load 0x5, 0xA, 0x3 with s_valid held, verify_en=0.
  - ccff_en is high for exactly 10 consecutive cycles.
  - Chain is loaded with bits 1,0,1,0,0,1,0,1,1,1; bits 2-3 of the last word are dropped.
  - done pulses once; s_ready is high for exactly 3 handshakes.
- Same load with verify_en=1 and the identical words re-sent: 20 shifts, mismatch_cnt=0, err=0, chain contents unchanged.
- verify_en=1 with pass-2 word 0 = 0x4 instead of 0x5: mismatch_cnt=1, err=1 after done.
- s_valid dropped for 3 cycles between words 1 and 2: ccff_en is low for those cycles, shift count is still 10, and chain contents match the first scenario.
- abort asserted after 6 shifts: next cycle ccff_en=0, busy=0, s_ready=0, no done. A subsequent start loads a full 10 bits.
- pReset asserted mid-LOAD: all outputs go to 0 asynchronously. start after release begins a fresh pass with word_cnt=0.

Source files
------------

// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain loader.
//   ccff_state_e : loader FSM states
//   ceil_div     : words per pass from chain length and word width
//   cnt_w        : width of a counter that must hold the value n
//   idx_w        : width of an index over n positions (at least 1)
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } ccff_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-to-bit serializer feeding the configuration chain.
// Holds one host word and shifts it out LSB-first, one bit per enabled cycle.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clr_i          : synchronous flush (drops the buffered word)
//   busy_i         : loader is in a shifting pass
//   room_i         : the pass still needs more words
//   last_word_i    : the word accepted now is the last of the pass
//   last_lim_i     : index of the final kept bit of the last word
//   s_data_i/s_valid_i/s_ready_o : host word stream
//   accept_o       : a word is taken this cycle
//   head_o         : current bit presented to the chain
//   vld_o          : buffer holds bits still to be shifted
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter  int WORD_W = 32,
  localparam int BIDX_W = idx_w(WORD_W)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              busy_i,
  input  logic              room_i,
  input  logic              last_word_i,
  input  logic [BIDX_W-1:0] last_lim_i,
  input  logic [WORD_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic              accept_o,
  output logic              head_o,
  output logic              vld_o
);

  logic [WORD_W-1:0] word_q;
  logic              vld_q;
  logic [BIDX_W-1:0] bidx_q;
  logic [BIDX_W-1:0] lim_q;
  logic              shift;

  assign shift = vld_q & busy_i;

  // A new word may land in the same cycle the previous word's top bit leaves,
  // which keeps the chain shifting at one bit per cycle across word borders.
  assign s_ready_o = busy_i & room_i &
                     (~vld_q | (shift & (bidx_q == BIDX_W'(WORD_W - 1))));
  assign accept_o  = s_valid_i & s_ready_o;
  assign head_o    = word_q[0];
  assign vld_o     = vld_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      vld_q  <= 1'b0;
      bidx_q <= '0;
      lim_q  <= BIDX_W'(WORD_W - 1);
    end else if (clr_i) begin
      word_q <= '0;
      vld_q  <= 1'b0;
      bidx_q <= '0;
      lim_q  <= BIDX_W'(WORD_W - 1);
    end else if (accept_o) begin
      word_q <= s_data_i;
      vld_q  <= 1'b1;
      bidx_q <= '0;
      // The last word of a pass may carry bits past the chain end; they are
      // never shifted because the buffer empties at the shorter limit.
      lim_q  <= last_word_i ? last_lim_i : BIDX_W'(WORD_W - 1);
    end else if (shift) begin
      word_q <= word_q >> 1;
      if (bidx_q == lim_q) begin
        vld_q  <= 1'b0;
        bidx_q <= '0;
      end else begin
        bidx_q <= bidx_q + BIDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain bitstream loader (prog_clk domain).
// Streams host words LSB-first into a CHAIN_LEN-flop daisy chain and can run a
// second pass that compares the chain tail against the re-sent bitstream.
//   prog_clk, pReset        : clock, asynchronous active-low reset
//   start, verify_en, abort : control (abort has priority over everything)
//   s_data/s_valid/s_ready  : host word stream
//   ccff_head, ccff_en      : serial bit and shift enable to the chain
//   ccff_tail               : serial bit returning from the chain end
//   busy, done              : pass in progress / one-cycle completion pulse
//   mismatch_cnt, err       : saturating verify mismatch count, nonzero flag
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify_en,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic              err
);

  localparam int NW       = ceil_div(CHAIN_LEN, WORD_W);
  localparam int BC_W     = cnt_w(CHAIN_LEN);
  localparam int WC_W     = cnt_w(NW);
  localparam int BIDX_W   = idx_w(WORD_W);
  localparam int LAST_LIM = CHAIN_LEN - (NW - 1) * WORD_W - 1;

  ccff_state_e      state_q;
  logic             busy_q;
  logic             done_q;
  logic             verify_q;
  logic [BC_W-1:0]  bit_cnt_q;
  logic [WC_W-1:0]  word_cnt_q;
  logic [CNT_W-1:0] mism_q;
  logic [CNT_W-1:0] mism_d;
  logic             accept;
  logic             vld;
  logic             shift;
  logic             last_shift;
  logic             miss;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  ccff_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk_i       (prog_clk),
    .rst_ni      (pReset),
    .clr_i       (abort),
    .busy_i      (busy_q),
    .room_i      (word_cnt_q < WC_W'(NW)),
    .last_word_i (word_cnt_q == WC_W'(NW - 1)),
    .last_lim_i  (BIDX_W'(LAST_LIM)),
    .s_data_i    (s_data),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .accept_o    (accept),
    .head_o      (ccff_head),
    .vld_o       (vld)
  );

  // Enable is an AND of two flops only, so no host input reaches the chain
  // clock gate combinationally.
  assign shift      = vld & busy_q;
  assign last_shift = shift & (bit_cnt_q == BC_W'(CHAIN_LEN - 1));

  // During VERIFY the tail flop holds the first-pass copy of the bit that is
  // being re-sent on the head right now.
  assign miss   = (state_q == VERIFY) & shift & (ccff_tail != ccff_head);
  assign mism_d = miss ? sat_inc(mism_q) : mism_q;

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      verify_q   <= 1'b0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      mism_q     <= '0;
    end else if (abort) begin
      // mismatch_cnt deliberately keeps its value across an abort
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= LOAD;
            busy_q     <= 1'b1;
            verify_q   <= verify_en;
            mism_q     <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
          end
        end
        LOAD, VERIFY: begin
          mism_q <= mism_d;
          if (accept) word_cnt_q <= word_cnt_q + WC_W'(1);
          if (shift)  bit_cnt_q  <= bit_cnt_q + BC_W'(1);
          if (last_shift) begin
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            if (state_q == LOAD && verify_q) begin
              state_q <= VERIFY;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ccff_en      = shift;
  assign busy         = busy_q;
  assign done         = done_q;
  assign mismatch_cnt = mism_q;
  assign err          = |mism_q;

endmodule

// File: tb/tb_ccff_loader.sv
module tb_ccff_loader;

  localparam int CL = 10;
  localparam int WW = 4;
  localparam int CW = 2;

  logic          prog_clk;
  logic          pReset;
  logic          start;
  logic          verify_en;
  logic          abort;
  logic [WW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          ccff_head;
  logic          ccff_en;
  logic          ccff_tail;
  logic          busy;
  logic          done;
  logic [CW-1:0] mismatch_cnt;
  logic          err;

  int checks;
  int failures;

  ccff_loader #(
    .CHAIN_LEN (CL),
    .WORD_W    (WW),
    .CNT_W     (CW)
  ) dut (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .start        (start),
    .verify_en    (verify_en),
    .abort        (abort),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .ccff_head    (ccff_head),
    .ccff_en      (ccff_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .mismatch_cnt (mismatch_cnt),
    .err          (err)
  );

  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  // Chain model: first bit shifted ends up in chain[CL-1] after CL shifts.
  logic [CL-1:0] chain;
  assign ccff_tail = chain[CL-1];
  always @(posedge prog_clk) begin
    if (ccff_en) chain <= {chain[CL-2:0], ccff_head};
  end

  typedef struct {
    logic [WW-1:0] data;
    int            gap;
  } feed_t;

  typedef struct {
    int            shifts;
    int            hs;
    int            idle;
    int            runs;
    logic [CW-1:0] mism;
    logic          err;
    logic [CL-1:0] chain;
  } exp_t;

  feed_t feed_q[$];
  exp_t  exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Stream driver: gap = cycles the word is withheld while s_ready is high.
  bit drv_hs;
  int drv_gap;
  initial begin
    s_valid = 1'b0;
    s_data  = '0;
    drv_gap = 0;
    forever begin
      @(negedge prog_clk);
      drv_hs = s_valid && s_ready;
      if (!s_valid && s_ready && drv_gap > 0) drv_gap--;
      @(posedge prog_clk);
      #1;
      if (drv_hs && feed_q.size() > 0) begin
        void'(feed_q.pop_front());
        if (feed_q.size() > 0) drv_gap = feed_q[0].gap;
      end
      if (feed_q.size() == 0) drv_gap = 0;
      if (feed_q.size() > 0 && drv_gap == 0) begin
        s_valid = 1'b1;
        s_data  = feed_q[0].data;
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  // Monitor: accumulates per-run activity, scores it when done pulses.
  int m_en;
  int m_hs;
  int m_idle;
  int m_runs;
  bit m_prev;
  initial begin
    exp_t e;
    m_en = 0; m_hs = 0; m_idle = 0; m_runs = 0; m_prev = 1'b0;
    forever begin
      @(negedge prog_clk);
      if (!pReset) begin
        m_en = 0; m_hs = 0; m_idle = 0; m_runs = 0; m_prev = 1'b0;
      end else begin
        if (ccff_en) begin
          m_en++;
          if (!m_prev) m_runs++;
        end
        m_prev = ccff_en;
        if (busy && !ccff_en) m_idle++;
        if (s_valid && s_ready) m_hs++;
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("done_expected", 0, 1);
          end else begin
            e = exp_q.pop_front();
            chk("shift_count", m_en, e.shifts);
            chk("handshakes", m_hs, e.hs);
            chk("idle_busy_cycles", m_idle, e.idle);
            chk("shift_runs", m_runs, e.runs);
            chk("mismatch_cnt", mismatch_cnt, e.mism);
            chk("err", err, e.err);
            chk("chain", chain, e.chain);
          end
          m_en = 0; m_hs = 0; m_idle = 0; m_runs = 0; m_prev = 1'b0;
        end
        if (abort) begin
          m_en = 0; m_hs = 0; m_idle = 0; m_runs = 0; m_prev = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic push_words(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                            input logic [WW-1:0] w2, input int gap2);
    feed_t f;
    f.data = w0; f.gap = 0;    feed_q.push_back(f);
    f.data = w1; f.gap = 0;    feed_q.push_back(f);
    f.data = w2; f.gap = gap2; feed_q.push_back(f);
  endtask

  task automatic push_exp(input int shifts, input int hs, input int idle, input int runs,
                          input logic [CW-1:0] mism, input logic e_err, input logic [CL-1:0] ch);
    exp_t e;
    e.shifts = shifts; e.hs = hs; e.idle = idle; e.runs = runs;
    e.mism = mism; e.err = e_err; e.chain = ch;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic v);
    tick();
    start = 1'b1;
    verify_en = v;
    tick();
    start = 1'b0;
    verify_en = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge prog_clk);
      got = done;
    end
    chk(name, got, 1);
  endtask

  initial begin
    bit got;
    checks = 0; failures = 0;
    pReset = 1'b0; start = 1'b0; verify_en = 1'b0; abort = 1'b0;

    // Reset state
    repeat (3) @(negedge prog_clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ccff_en", ccff_en, 0);
    chk("rst_ccff_head", ccff_head, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_mismatch", mismatch_cnt, 0);
    chk("rst_err", err, 0);
    pReset = 1'b1;

    // Plain load: bits 1,0,1,0,0,1,0,1,1,1 -> chain 0x297
    push_words(4'h5, 4'hA, 4'h3, 0);
    push_exp(10, 3, 1, 1, 2'd0, 1'b0, 10'h297);
    do_start(1'b0);
    wait_done("s1_done");

    // Load + verify with identical re-send
    push_words(4'h5, 4'hA, 4'h3, 0);
    push_words(4'h5, 4'hA, 4'h3, 0);
    push_exp(20, 6, 2, 2, 2'd0, 1'b0, 10'h297);
    do_start(1'b1);
    wait_done("s2_done");

    // Verify with one flipped bit (word 0 of pass 2 = 0x4)
    push_words(4'h5, 4'hA, 4'h3, 0);
    push_words(4'h4, 4'hA, 4'h3, 0);
    push_exp(20, 6, 2, 2, 2'd1, 1'b1, 10'h097);
    do_start(1'b1);
    wait_done("s3_done");
    repeat (3) tick();
    chk("hold_mismatch", mismatch_cnt, 1);
    chk("hold_err", err, 1);

    // Verify against fully inverted stream: 10 mismatches saturate at 3
    push_words(4'h5, 4'hA, 4'h3, 0);
    push_words(4'hA, 4'h5, 4'h0, 0);
    push_exp(20, 6, 2, 2, 2'd3, 1'b1, 10'h168);
    do_start(1'b1);
    wait_done("s_sat_done");

    // Stall of 3 cycles before the last word; a start while busy is ignored
    push_words(4'h5, 4'hA, 4'h3, 3);
    push_exp(10, 3, 4, 2, 2'd0, 1'b0, 10'h297);
    do_start(1'b0);
    repeat (3) tick();
    start = 1'b1;
    verify_en = 1'b1;
    tick();
    start = 1'b0;
    verify_en = 1'b0;
    wait_done("s4_done");

    // Abort after 6 shifts, then a full reload
    push_words(4'h5, 4'hA, 4'h3, 0);
    do_start(1'b0);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge prog_clk);
      #1;
      got = (m_en >= 6);
    end
    chk("abort_wait_shifts", got, 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ccff_en", ccff_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_s_ready", s_ready, 0);
    chk("abort_done", done, 0);
    feed_q.delete();
    repeat (4) tick();
    chk("abort_stays_idle", busy, 0);
    push_words(4'h5, 4'hA, 4'h3, 0);
    push_exp(10, 3, 1, 1, 2'd0, 1'b0, 10'h297);
    do_start(1'b0);
    wait_done("s5_done");

    // start and abort together in IDLE: abort wins
    tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_s_ready", s_ready, 0);

    // Asynchronous reset mid-load, then a fresh pass
    push_words(4'h5, 4'hA, 4'h3, 0);
    do_start(1'b0);
    repeat (4) tick();
    #2;
    pReset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ccff_en", ccff_en, 0);
    chk("mid_rst_ccff_head", ccff_head, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_mismatch", mismatch_cnt, 0);
    chk("mid_rst_err", err, 0);
    feed_q.delete();
    repeat (2) tick();
    @(negedge prog_clk);
    pReset = 1'b1;
    push_words(4'h5, 4'hA, 4'h3, 0);
    push_exp(10, 3, 1, 1, 2'd0, 1'b0, 10'h297);
    do_start(1'b0);
    wait_done("s6_done");

    repeat (3) tick();
    chk("expect_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
